// File: rtl/tv_recorder_pkg.sv
// Shared definitions for the test-vector recorder and the vector-file benches.
// Holds the FSM state encoding and the default record geometry.
package tv_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int TV_VEC_W  = 4;
  localparam int TV_DEPTH  = 16;
  localparam int TV_ADDR_W = $clog2(TV_DEPTH);

endpackage

// File: rtl/tv_buffer_ram.sv
// DEPTH x VEC_W register array holding captured records.
// It has a synchronous write port and an asynchronous read port.
module tv_buffer_ram #(
  parameter int VEC_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [VEC_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [VEC_W-1:0]  rdata
);

  logic [DEPTH-1:0][VEC_W-1:0] mem;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tv_recorder.sv
// Test-vector recorder: captures per-cycle sample records into a buffer, then
// streams them out over a valid/ready port in the same packed layout.
module tv_recorder
  import tv_recorder_pkg::*;
#(
  parameter int VEC_W  = TV_VEC_W,
  parameter int DEPTH  = TV_DEPTH,
  parameter int ADDR_W = TV_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_en,
  input  logic [VEC_W-1:0]  sample_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [VEC_W-1:0]  rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t            state, nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt_nxt;
  logic [VEC_W-1:0]  ram_q;
  logic              wr_en, start_ok, xfer, is_drain, last_hit;

  assign wr_en    = (state == CAPTURE) && sample_en;
  assign cnt_nxt  = count + {{ADDR_W{1'b0}}, wr_en};
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign is_drain = (state == DRAIN);
  assign last_hit = ({1'b0, rd_ptr} == (count - 1'b1));
  assign xfer     = is_drain && rd_ready;

  tv_buffer_ram #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (sample_data),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // A sample arriving together with stop is counted before the exit decision.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = CAPTURE;
      CAPTURE: begin
        if (cnt_nxt == FULL)  nxt = DRAIN;
        else if (stop)        nxt = (cnt_nxt == '0) ? DONE : DRAIN;
      end
      DRAIN:      if (xfer && last_hit) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_valid = is_drain;
    rd_last  = is_drain && last_hit;
    rd_data  = is_drain ? ram_q : '0;
    busy     = (state == CAPTURE) || is_drain;
    done     = (state == DONE);
  end

  // Start clears everything, including an overflow raised in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (start_ok) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= cnt_nxt;
      end
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      if (sample_en && ((state == DRAIN) || (state == DONE))) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tv_recorder.sv
// Randomised scoreboard bench for tv_recorder: a list-based capture model feeds
// an expected-record queue that an independent monitor drains and compares.
module tb_tv_recorder;

  localparam int VEC_W  = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0, stop = 1'b0, sample_en = 1'b0, rd_ready = 1'b0;
  logic [VEC_W-1:0]  sample_data = '0;
  logic              rd_valid, rd_last, busy, done, overflow;
  logic [VEC_W-1:0]  rd_data;
  logic [ADDR_W:0]   count;

  int errors = 0;
  int checks = 0;

  // model state: capture list, expected drain records, flags
  logic [VEC_W-1:0] m_store[$];
  logic [VEC_W-1:0] exp_q[$];
  bit m_cap = 0, m_started = 0, m_ovf = 0;
  int m_count = 0;

  bit               held_v = 0;
  logic [VEC_W-1:0] held_d;
  logic             held_l;

  tv_recorder #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .sample_en   (sample_en),
    .sample_data (sample_data),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard, and stall hold.
  always @(negedge clk) begin
    if (!reset_n) held_v = 0;
    else if (rd_valid) begin
      if (held_v) begin
        chk("hold_data", rd_data, held_d);
        chk("hold_last", rd_last, held_l);
      end
      if (rd_ready) begin
        chk("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [VEC_W-1:0] e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
          chk("rd_last", rd_last, exp_q.size() == 0);
        end
        held_v = 0;
      end else begin
        held_v = 1;
        held_d = rd_data;
        held_l = rd_last;
      end
    end else begin
      chk("idle_data", rd_data, 0);
      chk("idle_last", rd_last, 0);
      held_v = 0;
    end
  end

  // One clock of stimulus; the model is advanced from the same inputs.
  task automatic step(bit st, bit sp, bit se, logic [VEC_W-1:0] sd, bit rr);
    start = st; stop = sp; sample_en = se; sample_data = sd; rd_ready = rr;
    if (se && !m_cap && m_started) m_ovf = 1;
    if (st && !m_cap && exp_q.size() == 0) begin
      m_cap = 1; m_started = 1; m_ovf = 0; m_count = 0;
      m_store.delete();
    end else if (m_cap) begin
      if (se) m_store.push_back(sd);
      if ((se && m_store.size() == DEPTH) || sp) begin
        m_cap = 0;
        m_count = m_store.size();
        foreach (m_store[i]) exp_q.push_back(m_store[i]);
      end
    end
    @(posedge clk); #1;
    start = 0; stop = 0; sample_en = 0;
  endtask

  task automatic drain(int mode, bit inj);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      bit rr;
      case (mode)
        0:       rr = 1;
        1:       rr = (k % 4 == 0) || (k % 4 == 3);
        default: rr = 1'($urandom % 2);
      endcase
      step(0, 0, inj && ($urandom % 6 == 0), VEC_W'($urandom), rr);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    chk("done_after_drain", done, 1);
    chk("busy_after_drain", busy, 0);
    chk("count_after_drain", count, m_count);
    chk("ovf_after_drain", overflow, m_ovf);
  endtask

  initial begin
    #3;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    #24 reset_n = 1;
    @(posedge clk); #1;
    rd_ready = 1;

    // basic 3-record capture
    step(1, 0, 0, 0, 1);
    step(0, 0, 1, 4'b0011, 1);
    step(0, 0, 1, 4'b1010, 1);
    step(0, 0, 1, 4'b1111, 1);
    step(0, 1, 0, 0, 1);
    chk("t1_count", count, 3);
    chk("t1_busy", busy, 1);
    drain(0, 0);

    // fill to DEPTH, auto-drain
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, VEC_W'(i), 1);
    chk("t2_count", count, DEPTH);
    chk("t2_busy", busy, 1);
    drain(0, 0);

    // backpressure 1,0,0,1
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, VEC_W'($urandom), 1);
    step(0, 1, 0, 0, 0);
    drain(1, 0);

    // stop with nothing stored
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("t4_done", done, 1);
    chk("t4_count", count, 0);
    chk("t4_busy", busy, 0);

    // overflow during drain, cleared by start
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, VEC_W'(i + 9), 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 4'hA, 1);
    chk("t5_ovf_set", overflow, 1);
    drain(0, 0);
    step(1, 0, 0, 0, 1);
    chk("t5_ovf_clr", overflow, 0);
    chk("t5_count_clr", count, 0);
    step(0, 1, 0, 0, 1);
    chk("t5_done", done, 1);

    // reset mid-drain after 2 of 5 records
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, VEC_W'($urandom), 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t6_remaining", exp_q.size(), 3);
    #2 reset_n = 0;
    #1;
    exp_q.delete();
    m_cap = 0; m_started = 0; m_ovf = 0; m_count = 0;
    chk("t6_valid", rd_valid, 0);
    chk("t6_data", rd_data, 0);
    chk("t6_last", rd_last, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_count", count, 0);
    #10 reset_n = 1;
    @(posedge clk); #1;

    // randomised captures and drains
    for (int it = 0; it < 40; it++) begin
      int len, k;
      len = $urandom_range(0, 18);
      k = 0;
      step(1, 0, 0, 0, 1);
      while (m_cap && k < 60) begin
        bit se;
        se = ($urandom % 4) != 0;
        step(0, k >= len, se, VEC_W'($urandom), 1);
        k++;
      end
      chk("rnd_cap_end", m_cap, 0);
      if (exp_q.size() == 0) begin
        chk("rnd_empty_done", done, 1);
        chk("rnd_empty_count", count, 0);
      end else begin
        chk("rnd_busy", busy, 1);
        drain(2, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
